cache_plru_memory: RTL and testbench
====================================

CACHE_PLRU_MEMORY -- requirements
Module: cache_plru_memory

Interface
REQ-001 WAYS, 4, associativity; SHALL be a power of two in 2..8.
REQ-002 SETS, 8, number of sets; SHALL be a power of two in 2..256.
REQ-003 IDX_W = log2(SETS), WAY_W = log2(WAYS), both derived; neither SHALL be overridable.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  starts a clear sweep of all replacement state.
REQ-007 busy  output  1  high while a clear sweep is in progress.
REQ-008 lookup_valid  input  1  requests the victim way for lookup_index.
REQ-009 lookup_index  input  IDX_W  set whose victim is requested.
REQ-010 victim_valid  output  1  high one cycle after an accepted lookup.
REQ-011 victim_way  output  WAY_W  pseudo-LRU victim way of the looked-up set.
REQ-012 touch_valid  input  1  records an access (hit or fill) to touch_way in touch_index.
REQ-013 touch_index  input  IDX_W  set being updated.
REQ-014 touch_way  input  WAY_W  way just accessed.

Function
REQ-015 Per set, the block SHALL store WAYS-1 tree-PLRU bits in heap order: node 0 is the root; the children of node n are 2n+1 (left) and 2n+2 (right).
REQ-016 The path of way w SHALL be given by the bits of w from MSB to LSB, with 0 selecting left and 1 selecting right.
REQ-017 Victim selection SHALL walk from the root, going left on a node bit of 0 and right on 1; the leaf reached is the victim_way.
REQ-018 On an accepted touch, every node on the path of touch_way SHALL be set to point away from it (node bit = inverse of the path direction); off-path nodes SHALL be unchanged.
REQ-019 Lookup latency SHALL be 1 cycle: lookup in cycle t -> victim_valid=1 and victim_way registered in cycle t+1; otherwise victim_valid=0 and victim_way holds its last value.
REQ-020 A touch and a lookup to the same index in the same cycle SHALL return the victim computed from the post-touch state (write-first forwarding).
REQ-021 A touch and a lookup to different indices in the same cycle SHALL both complete independently.
REQ-022 FSM states SHALL be IDLE and CLEAR; CLEAR writes all-zero bits to one set per cycle, from set 0 up to set SETS-1, then returns to IDLE.
REQ-023 flush sampled high in IDLE SHALL enter CLEAR on the next edge; busy SHALL be high for exactly SETS cycles.
REQ-024 flush sampled high during CLEAR SHALL restart the sweep at set 0, extending busy.
REQ-025 While busy=1, lookup and touch SHALL be ignored: no state change, and victim_valid=0 in the following cycle.
REQ-026 The clear counter SHALL not wrap into a second sweep unless flush is re-asserted.

Reset
REQ-027 rst_n low SHALL immediately force state=CLEAR, clear counter=0, busy=1, victim_valid=0 and victim_way=0.
REQ-028 The PLRU array SHALL not be reset directly; it SHALL be zeroed by the CLEAR sweep after rst_n deasserts.
REQ-029 Assertion of rst_n mid-sweep or mid-lookup SHALL abort the operation and restart per REQ-027.
REQ-030 After the sweep completes, a lookup of any set SHALL return victim_way=0.

Verification (WAYS=4, SETS=8)
REQ-031 Reset release -> busy=1 for 8 cycles then 0; a lookup of set 5 then returns victim_valid=1 and victim_way=0 one cycle later.
REQ-032 Touch set 3 way 0 -> bits {n0,n1,n2}={1,1,0}; a lookup of set 3 returns way 2. Then touch way 2 -> lookup returns way 1.
REQ-033 In set 1, touch ways 0,1,2,3 on consecutive cycles -> lookup returns way 0; set 2 is unaffected and returns way 0.
REQ-034 Same-cycle touch set 4 way 2 with lookup set 4 -> victim_way=0, from the post-touch state.
REQ-035 flush after touches, re-flush at sweep cycle 5, touch/lookup attempted during busy -> busy lasts 5+8 cycles, victim_valid stays 0, and all sets return way 0 afterwards.
REQ-036 rst_n pulsed low mid-lookup -> victim_valid=0 and busy=1 immediately, with a full 8-cycle sweep after release.

Source files
------------

// File: rtl/cache_plru_memory.sv
// Tree pseudo-LRU replacement store: one (WAYS-1)-bit heap-ordered tree per set, victim lookup and touch update.
// Latency: victim_valid/victim_way registered 1 cycle after an accepted lookup; a same-set touch is forwarded (write-first).
// Backpressure: none on lookup/touch; both are dropped while busy (reset or flush sweep zeroing one set per cycle).
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   flush / busy                - start a clear sweep / sweep in progress
//   lookup_valid, lookup_index  - request the victim of a set
//   victim_valid, victim_way    - registered victim result
//   touch_valid, touch_index,
//   touch_way                   - record an access (hit or fill) to a way of a set
module cache_plru_memory #(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 8,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             busy,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_index,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    input  logic             touch_valid,
    input  logic [IDX_W-1:0] touch_index,
    input  logic [WAY_W-1:0] touch_way
);

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             busy_q, busy_d;
    logic             victim_valid_q, victim_valid_d;
    logic [WAY_W-1:0] victim_way_q, victim_way_d;

    // Replacement bits are deliberately not reset; the sweep zeroes them.
    logic [WAYS-2:0]  plru_q [SETS];

    logic             lkp_acc, tch_acc;
    logic [WAYS-2:0]  tch_bits, lkp_bits;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WAYS-2:0]  wr_dat;

    // Every node on the path of 'way' is pointed away from it.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                    input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        int              n;
        logic            dir;
        r = bits;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir  = way[WAY_W-1-l];
            r[n] = ~dir;
            n    = 2 * n + 1 + int'(dir);
        end
        return r;
    endfunction

    // Walk from the root: 0 goes left, 1 goes right; the path bits are the way number.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAY_W-1:0] v;
        int               n;
        logic             b;
        v = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b              = bits[n];
            v[WAY_W-1-l]   = b;
            n              = 2 * n + 1 + int'(b);
        end
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (flush) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == IDX_W'(SETS - 1)) begin
                    state_d   = S_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    always_comb begin
        lkp_acc  = lookup_valid && !busy_q;
        tch_acc  = touch_valid && !busy_q;
        tch_bits = plru_touch(plru_q[touch_index], touch_way);
        // Same-set touch in the same cycle: the lookup sees the updated tree.
        lkp_bits = (tch_acc && (touch_index == lookup_index)) ? tch_bits : plru_q[lookup_index];

        victim_valid_d = lkp_acc;
        victim_way_d   = lkp_acc ? plru_victim(lkp_bits) : victim_way_q;

        wr_en  = busy_q || tch_acc;
        wr_idx = busy_q ? clr_cnt_q : touch_index;
        wr_dat = busy_q ? '0 : tch_bits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_CLEAR;
            clr_cnt_q      <= '0;
            busy_q         <= 1'b1;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            busy_q         <= busy_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            plru_q[wr_idx] <= wr_dat;
        end
    end

    assign busy         = busy_q;
    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_cache_plru_memory.sv
module tb_cache_plru_memory;

    localparam int WAYS = 4;
    localparam int SETS = 8;
    localparam int WW   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       busy;
    logic       lookup_valid = 1'b0;
    logic [2:0] lookup_index = '0;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       touch_valid = 1'b0;
    logic [2:0] touch_index = '0;
    logic [1:0] touch_way = '0;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: per set, node bits of a heap-ordered binary tree.
    bit mdl [SETS][WAYS-1];
    int exp_vw = 0;

    typedef struct {
        bit tv; int ti; int tw;
        bit lv; int li;
        bit evv; int evw;
    } vec_t;
    vec_t vecs [15];

    cache_plru_memory #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .busy         (busy),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .touch_valid  (touch_valid),
        .touch_index  (touch_index),
        .touch_way    (touch_way)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS - 1; n++)
                mdl[s][n] = 1'b0;
    endfunction

    // The way number, read MSB first, is the left/right path; each node on it points the other way.
    function automatic void mdl_touch(input int s, input int w);
        int node = 0;
        for (int l = 0; l < WW; l++) begin
            int d = (w >> (WW - 1 - l)) & 1;
            mdl[s][node] = (d == 0);
            node = 2 * node + 1 + d;
        end
    endfunction

    function automatic int mdl_victim(input int s);
        int node = 0;
        int w = 0;
        for (int l = 0; l < WW; l++) begin
            int d = int'(mdl[s][node]);
            w = w * 2 + d;
            node = 2 * node + 1 + d;
        end
        return w;
    endfunction

    task automatic drive(input bit tv, input int ti, input int tw, input bit lv, input int li);
        touch_valid  = tv;
        touch_index  = 3'(ti);
        touch_way    = 2'(tw);
        lookup_valid = lv;
        lookup_index = 3'(li);
    endtask

    task automatic idle_inputs();
        drive(0, 0, 0, 0, 0);
    endtask

    // One idle-state cycle: model applies touch first, then lookup (write-first).
    task automatic apply(input string nm, input bit tv, input int ti, input int tw,
                         input bit lv, input int li);
        drive(tv, ti, tw, lv, li);
        if (tv) mdl_touch(ti, tw);
        if (lv) exp_vw = mdl_victim(li);
        step();
        idle_inputs();
        check({nm, "_vv"}, victim_valid, 32'(lv));
        check({nm, "_vw"}, victim_way, exp_vw);
    endtask

    task automatic count_busy(inout int n);
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        int bad;

        vecs[0]  = '{0, 0, 0, 1, 5, 1, 0};
        vecs[1]  = '{1, 3, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 3, 1, 2};
        vecs[3]  = '{1, 3, 2, 0, 0, 0, 2};
        vecs[4]  = '{0, 0, 0, 1, 3, 1, 1};
        vecs[5]  = '{1, 1, 0, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 1, 0, 0, 0, 1};
        vecs[7]  = '{1, 1, 2, 0, 0, 0, 1};
        vecs[8]  = '{1, 1, 3, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 1, 1, 1, 0};
        vecs[10] = '{0, 0, 0, 1, 2, 1, 0};
        vecs[11] = '{0, 0, 0, 1, 3, 1, 1};
        vecs[12] = '{1, 4, 2, 1, 4, 1, 0};
        vecs[13] = '{1, 6, 1, 1, 7, 1, 0};
        vecs[14] = '{0, 0, 0, 1, 6, 1, 2};

        // Reset state
        repeat (3) step();
        check("reset_busy", busy, 1);
        check("reset_vv", victim_valid, 0);
        check("reset_vw", victim_way, 0);

        rst_n = 1'b1;
        n = 0;
        count_busy(n);
        check("reset_sweep_len", n, 8);
        mdl_clear();
        exp_vw = 0;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].tv, vecs[i].ti, vecs[i].tw, vecs[i].lv, vecs[i].li);
            if (vecs[i].tv) mdl_touch(vecs[i].ti, vecs[i].tw);
            if (vecs[i].lv) exp_vw = mdl_victim(vecs[i].li);
            step();
            idle_inputs();
            check($sformatf("vec%0d_vv", i), victim_valid, 32'(vecs[i].evv));
            check($sformatf("vec%0d_vw", i), victim_way, vecs[i].evw);
        end

        // Flush, re-flush during the 5th busy cycle, traffic ignored while busy
        flush = 1'b1;
        step();
        flush = 1'b0;
        n = 1;
        bad = 0;
        repeat (4) begin
            drive(1, $urandom_range(0, 7), $urandom_range(0, 3), 1, $urandom_range(0, 7));
            step();
            n++;
            if (victim_valid !== 1'b0) bad++;
        end
        flush = 1'b1;
        drive(1, $urandom_range(0, 7), $urandom_range(0, 3), 1, $urandom_range(0, 7));
        step();
        flush = 1'b0;
        if (victim_valid !== 1'b0) bad++;
        while (busy === 1'b1 && n < 100) begin
            n++;
            drive(1, $urandom_range(0, 7), $urandom_range(0, 3), 1, $urandom_range(0, 7));
            step();
            if (victim_valid !== 1'b0) bad++;
        end
        idle_inputs();
        check("reflush_busy_len", n, 13);
        check("busy_vv_leaks", bad, 0);
        mdl_clear();
        exp_vw = 0;
        step();
        check("no_wrap_busy", busy, 0);

        for (int s = 0; s < SETS; s++)
            apply($sformatf("post_flush_set%0d", s), 0, 0, 0, 1, s);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int ti = $urandom_range(0, 7);
            int li = ($urandom_range(0, 2) == 0) ? ti : $urandom_range(0, 7);
            apply("rand", 1'($urandom_range(0, 1)), ti, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), li);
        end

        // Reset pulsed mid-lookup
        apply("pre_rst_touch", 1, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 5);
        step();
        idle_inputs();
        check("pre_rst_vv", victim_valid, 1);
        check("pre_rst_vw", victim_way, mdl_victim(5));
        rst_n = 1'b0;
        #1;
        check("rst_pulse_vv", victim_valid, 0);
        check("rst_pulse_busy", busy, 1);
        check("rst_pulse_vw", victim_way, 0);
        #1;
        rst_n = 1'b1;
        n = 0;
        count_busy(n);
        check("rst_pulse_sweep_len", n, 8);
        mdl_clear();
        exp_vw = 0;
        apply("post_rst_set5", 0, 0, 0, 1, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
